// File: rtl/clock_divider.sv
// ---------------------------------------------------------------------------
// clock_divider
//
// Clock-enable divider. Counts rising edges of clk on which enable is high and
// fires a terminal event once every DIVIDE such edges. out1 is a registered
// clock-enable for slower logic; it never drives a real clock net.
//
// Build option (macro CLOCK_DIVIDER_TOGGLE_EN):
//   undefined : strobe mode, out1 is a one-clk pulse after each terminal event
//   defined   : toggle mode, out1 inverts on each terminal event (50% duty,
//               period 2*DIVIDE enabled cycles)
//
// Parameters:
//   DIVIDE_BITS  counter width in bits (default 7)
//   DIVIDE       division ratio, 1 <= DIVIDE <= 2**DIVIDE_BITS (default 100)
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   rst     in   asynchronous, active-high reset (clears count and out1)
//   enable  in   count qualifier; the counter holds while low
//   out1    out  registered divided output (strobe or toggle)
// ---------------------------------------------------------------------------
module clock_divider #(
    parameter int DIVIDE_BITS = 7,
    parameter int DIVIDE      = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic out1
);

    // Refuse to elaborate with a ratio the counter cannot represent.
    generate
        if (DIVIDE < 1 || 64'(DIVIDE) > (64'd1 << DIVIDE_BITS)) begin : g_bad_param
            $error("clock_divider: DIVIDE=%0d illegal for DIVIDE_BITS=%0d", DIVIDE, DIVIDE_BITS);
        end
    endgenerate

    // Last value the counter reaches before wrapping back to zero. Because the
    // count wraps here, it never reaches 2**DIVIDE_BITS and needs no carry bit.
    localparam logic [DIVIDE_BITS-1:0] LAST_COUNT = DIVIDE_BITS'(DIVIDE - 1);

    logic [DIVIDE_BITS-1:0] count_reg;
    logic [DIVIDE_BITS-1:0] count_next;
    logic                   out1_reg;
    logic                   out1_next;
    logic                   terminal;

    always_comb begin
        terminal   = enable && (count_reg == LAST_COUNT);
        count_next = count_reg;
        if (enable) begin
            if (terminal) begin
                count_next = '0;
            end else begin
                count_next = count_reg + DIVIDE_BITS'(1);
            end
        end
`ifdef CLOCK_DIVIDER_TOGGLE_EN
        // Toggle mode: invert on each terminal event, hold otherwise
        // (including while enable is low).
        out1_next = terminal ? ~out1_reg : out1_reg;
`else
        // Strobe mode: high only for the cycle after a terminal event.
        out1_next = terminal;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            out1_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            out1_reg  <= out1_next;
        end
    end

    // Output comes straight from a flop: no combinational path from enable.
    assign out1 = out1_reg;

endmodule

// File: tb/tb_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_clock_divider
//
// Self-checking bench for clock_divider. Three instances share clk, rst and
// enable: the nominal DIVIDE=100 build, DIVIDE=1, and DIVIDE=4 with a 2-bit
// counter (ratio equal to 2**DIVIDE_BITS). The reference model only counts
// enabled edges since reset and derives the expected outputs arithmetically.
// Honours CLOCK_DIVIDER_TOGGLE_EN to pick strobe or toggle expectations.
// ---------------------------------------------------------------------------
module tb_clock_divider;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic enable = 1'b0;
    logic out1_a;
    logic out1_b;
    logic out1_c;

    int errors = 0;
    int checks = 0;

    // Reference model state: enabled edges since reset, and whether the most
    // recent edge was an enabled (non-reset) edge.
    int ticks   = 0;
    bit last_en = 1'b0;

    always #5 clk = ~clk;

    clock_divider #(.DIVIDE_BITS(7), .DIVIDE(100)) dut (
        .clk(clk), .rst(rst), .enable(enable), .out1(out1_a)
    );

    clock_divider #(.DIVIDE_BITS(1), .DIVIDE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .out1(out1_b)
    );

    clock_divider #(.DIVIDE_BITS(2), .DIVIDE(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .out1(out1_c)
    );

    // Expected out1 of a divider with ratio div after the current model state.
    function automatic logic exp_out(input int div);
`ifdef CLOCK_DIVIDER_TOGGLE_EN
        return ((ticks / div) % 2) == 1;
`else
        return last_en && ticks > 0 && (ticks % div) == 0;
`endif
    endfunction

    // Drive enable, advance one rising edge, update the model, settle 1 ns.
    task automatic tick(input logic en);
        enable = en;
        @(posedge clk);
        if (!rst) begin
            if (en) ticks++;
            last_en = en;
        end
        #1;
    endtask

    // Assert rst between edges; the model clears at once.
    task automatic assert_reset();
        rst = 1'b1;
        #1;
        ticks   = 0;
        last_en = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        enable = 1'b1;
        #2;
        assert_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            checks++;
            if (out1_a !== 1'b0 || dut.count_reg !== 7'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d out1=%b count=%0d, want out1=0 count=0", i, out1_a, dut.count_reg);
            end
        end
        rst = 1'b0;
        $display("reset: held 3 cycles with enable high, out1=%b count=%0d", out1_a, dut.count_reg);
    endtask

    task automatic test_enable_low();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            checks++;
            if (out1_a !== 1'b0 || dut.count_reg !== 7'd0) begin
                errors++;
                $display("FAIL enable_low cyc%0d out1=%b count=%0d, want out1=0 count=0", i, out1_a, dut.count_reg);
            end
        end
        $display("enable_low: 10 cycles, out1=%b count=%0d", out1_a, dut.count_reg);
    endtask

    // 201 consecutive enabled edges: covers edges 33, 99, 100, 101 and 200.
    task automatic test_steady_run();
        for (int i = 1; i <= 201; i++) begin
            tick(1'b1);
            checks++;
            if (out1_a !== exp_out(100) || dut.count_reg !== 7'(ticks % 100)) begin
                errors++;
                $display("FAIL steady_edge%0d out1=%b count=%0d, want out1=%b count=%0d",
                         i, out1_a, dut.count_reg, exp_out(100), ticks % 100);
            end
            if (i == 33 || i == 99 || i == 100 || i == 101 || i == 200)
                $display("steady: edge %0d out1=%b count=%0d", i, out1_a, dut.count_reg);
        end
    endtask

    // 50 enabled, 20 idle, 50 enabled: the period completes only at the end.
    task automatic test_gated();
        int highs;
        assert_reset();
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 125; i++) begin
            tick((i < 50 || (i >= 70 && i < 120)) ? 1'b1 : 1'b0);
            if (out1_a === 1'b1) highs++;
            checks++;
            if (out1_a !== exp_out(100)) begin
                errors++;
                $display("FAIL gated_cyc%0d out1=%b want %b (enabled edges %0d)", i, out1_a, exp_out(100), ticks);
            end
        end
`ifndef CLOCK_DIVIDER_TOGGLE_EN
        checks++;
        if (highs != 1) begin
            errors++;
            $display("FAIL gated_pulse_count got %0d pulses want 1", highs);
        end
`endif
        $display("gated: 100 enabled edges over 125 cycles, out1 high for %0d cycles", highs);
    endtask

    // Reset pulsed between edges at count 60, then a full period after release.
    task automatic test_async_reset();
        assert_reset();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) tick(1'b1);
        assert_reset();
        checks++;
        if (out1_a !== 1'b0 || dut.count_reg !== 7'd0) begin
            errors++;
            $display("FAIL async_reset_mid out1=%b count=%0d want out1=0 count=0", out1_a, dut.count_reg);
        end
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 101; i++) begin
            tick(1'b1);
            checks++;
            if (out1_a !== exp_out(100)) begin
                errors++;
                $display("FAIL async_release_edge%0d out1=%b want %b", i, out1_a, exp_out(100));
            end
        end
        $display("async_reset: cleared at count 60, next period checked over 101 edges");
    endtask

    // Reset arriving while out1 is high must clear it without a clock edge.
    task automatic test_reset_on_high();
        assert_reset();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick(1'b1);
        checks++;
        if (out1_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_high out1=%b want 1", out1_a);
        end
        assert_reset();
        checks++;
        if (out1_a !== 1'b0 || out1_b !== 1'b0 || out1_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_high out1 a/b/c=%b%b%b want 000", out1_a, out1_b, out1_c);
        end
        #1;
        rst = 1'b0;
        $display("reset_on_high: out1 cleared asynchronously");
    endtask

    // DIVIDE=1 and DIVIDE=4 (full 2-bit range) with enable held high.
    task automatic test_small_divides();
        assert_reset();
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1);
            checks++;
            if (out1_b !== exp_out(1) || out1_c !== exp_out(4) || dut4.count_reg !== 2'(ticks % 4)) begin
                errors++;
                $display("FAIL small_div_edge%0d div1=%b want %b div4=%b want %b count4=%0d want %0d",
                         i, out1_b, exp_out(1), out1_c, exp_out(4), dut4.count_reg, ticks % 4);
            end
        end
        $display("small_divides: 12 edges, div1 out1=%b div4 out1=%b", out1_b, out1_c);
    endtask

    // Random enable with occasional asynchronous resets; all three instances.
    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                assert_reset();
                #1;
                rst = 1'b0;
            end
            tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            checks++;
            if (out1_a !== exp_out(100) || out1_b !== exp_out(1) || out1_c !== exp_out(4)
                || dut.count_reg !== 7'(ticks % 100)) begin
                errors++;
                $display("FAIL random_cyc%0d a/b/c=%b%b%b want %b%b%b count=%0d want %0d",
                         i, out1_a, out1_b, out1_c, exp_out(100), exp_out(1), exp_out(4),
                         dut.count_reg, ticks % 100);
            end
        end
        $display("random: 1500 cycles, final enabled edge count %0d", ticks);
    endtask

    initial begin
        test_reset();
        test_enable_low();
        test_steady_run();
        test_gated();
        test_async_reset();
        test_reset_on_high();
        test_small_divides();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
